// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM encoding, default width.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // One-hot mask for a requester index.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to prio.
module alu_rr_pick
    import alu_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       winner
);

    // Resolve the winner index and its one-hot grant.
    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        case (req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = prio;
            default: winner = 1'b0;
        endcase
        if (req_valid != 2'b00) begin
            grant = req_onehot(winner);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between two requesters.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1 on the same channel; valid never depends on ready, ready may depend
// on valid (req_ready is combinational from req_valid in IDLE).
module alu_arbiter #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [7:0]          req_ctrl,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_zero,
    output logic [3:0]          alu_ctrl,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic                alu_zero
);
    import alu_pkg::*;

    state_t              state;
    logic                prio;
    logic                owner;
    logic [3:0]          op_ctrl;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [1:0]          grant;
    logic                winner;
    logic [3:0]          sel_ctrl;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;

    alu_rr_pick u_pick (
        .req_valid (req_valid),
        .prio      (prio),
        .grant     (grant),
        .winner    (winner)
    );

    // Route the winning requester's operands toward the operand registers.
    always_comb begin
        sel_ctrl = winner ? req_ctrl[7:4]              : req_ctrl[3:0];
        sel_a    = winner ? req_a[2*DATA_W-1:DATA_W]   : req_a[DATA_W-1:0];
        sel_b    = winner ? req_b[2*DATA_W-1:DATA_W]   : req_b[DATA_W-1:0];
    end

    // Ready only while idle; response valid only toward the current owner.
    always_comb begin
        req_ready = (state == IDLE) ? grant : 2'b00;
        rsp_valid = (state == RESP) ? req_onehot(owner) : 2'b00;
    end

    // Operand registers feed the ALU directly, so it holds still outside EXEC.
    assign alu_ctrl = op_ctrl;
    assign alu_a    = op_a;
    assign alu_b    = op_b;

    // Arbitration FSM: accept, run the ALU for one cycle, hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            owner    <= 1'b0;
            op_ctrl  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        op_ctrl <= sel_ctrl;
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        owner   <= winner;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_out;
                    rsp_zero <= alu_zero;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        prio  <= ~owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter that shares the single-cycle 32-bit ALU between independent clients, for example the main execute path and an auxiliary compare/address unit. It accepts one operation at a time through a valid/ready handshake and drives registered `aluctrl`/`a`/`b` to the shared ALU. It captures `aluout`/`zero` and returns them to the granted requester through a response handshake.

## Interface
- `DATA_W`, 32, operand/result width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  per-requester request valid; bit i is requester i
- `req_ready`  out  2  per-requester request accept
- `req_ctrl`  in  8  opcodes; [3:0] is requester 0, [7:4] is requester 1
- `req_a`  in  2*DATA_W  operand A; [DATA_W-1:0] is requester 0
- `req_b`  in  2*DATA_W  operand B, same packing as `req_a`
- `rsp_valid`  out  2  per-requester response valid
- `rsp_ready`  in  2  per-requester response accept
- `rsp_data`  out  DATA_W  result; shared bus, qualified by `rsp_valid`
- `rsp_zero`  out  1  captured ALU zero flag
- `alu_ctrl`  out  4  to ALU `aluctrl`
- `alu_a`, `alu_b`  out  DATA_W  to ALU operands
- `alu_out`  in  DATA_W  from ALU result
- `alu_zero`  in  1  from ALU zero

## Operation
- **Opcodes**, passed through unchanged:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (unsigned compare)
  - Any other code: the ALU returns 0 and zero=1. The arbiter neither traps nor flags it.
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready` is combinational: the winner's bit is 1 only when in IDLE and the winner's `req_valid`=1. All other bits are 0.
  - Winner: if exactly one `req_valid` bit is set, that requester wins. If both are set, the requester named by priority pointer `prio` wins.
  - On handshake: latch ctrl, a and b into operand registers, record `owner`, go to EXEC.
- **EXEC**
  - The operand registers drive `alu_ctrl`/`alu_a`/`alu_b`.
  - At the end of the cycle, capture `alu_out` into the `rsp_data` register and `alu_zero` into the `rsp_zero` register.
  - Go to RESP.
- **RESP**
  - `rsp_valid[owner]`=1.
  - When `rsp_ready[owner]`=1: set `prio` to the other requester, go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- **Pointer:** `prio` updates only on response completion. A requester that completed an operation loses ties on the next arbitration.
- **ALU outputs:** `alu_*` hold the last operand-register values outside EXEC, so the ALU does not toggle needlessly.
- **Operand stability:** a requester may change its request inputs after its handshake; the arbiter has already latched them.

## Timing
- **Reset values:**
  - State: IDLE
  - `prio`: 0
  - `req_ready`, `rsp_valid`: 2'b00
  - `rsp_data`: 0
  - `rsp_zero`: 0
  - `alu_ctrl`, `alu_a`, `alu_b`: 0
- **Latency:** request handshake in cycle N; ALU evaluates in N+1; `rsp_valid` is high from N+2.
- **Throughput:** at most one operation per 3 cycles with `rsp_ready` tied high. The next request can be accepted in the cycle after the response handshake.
- **Backpressure:** while `rsp_ready[owner]`=0, `rsp_valid`, `rsp_data` and `rsp_zero` hold stable, and `req_ready`=0 for both requesters.
- **Reset mid-operation:** asserting `rst_n` low in EXEC or RESP drops the transaction. No response is produced and `prio` returns to 0.
- **Requests in RESP:** `req_valid` from either requester during RESP waits. Arbitration occurs in the following IDLE cycle using the updated `prio`.
- **Withdrawn request:** a requester that drops `req_valid` before its handshake is not served. No state is retained for it.

## Structure
- Shared package `alu_pkg`:
  - opcode constants: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`
  - state encoding: IDLE, EXEC, RESP
  - `DATA_W` default
- Natural sub-module: `alu_rr_pick`. It is combinational: inputs are `req_valid[1:0]` and `prio`; outputs are `grant` (one-hot) and `winner` index.
- The ALU itself is instantiated outside this block, at the level where the datapath wires it.

## Test plan
- **Single request:** requester 0 ADD, a=5, b=7 -> `req_ready[0]` in the same cycle; `rsp_valid[0]` 2 cycles later with `rsp_data`=12, `rsp_zero`=0.
- **Tie fairness:** both requesters valid from reset with ops 0+1 and 0+2 -> requester 0 is served first (data 1), then requester 1 (data 2). Repeating the tie serves requester 0 then 1 again.
- **Flags and SLT:**
  - SUB 9-9 -> data 0, zero 1.
  - SLT 3,8 -> data 1.
  - OR 0xF0|0x0F -> 0xFF.
- **Backpressure:** `rsp_ready[1]` held 0 for 5 cycles while requester 0 is valid -> `rsp_data` stable and `req_ready`=0. Requester 0 is accepted in the first IDLE cycle after the release.
- **Reset during EXEC:** -> all outputs 0 and no `rsp_valid` pulse. A subsequent tie is served requester 0 first.
- **Illegal opcode:** ctrl 1111, a=3, b=4 -> data 0, zero 1, normal 3-cycle handshake.
